// File: rtl/data_loader.sv
// -----------------------------------------------------------------------------
// data_loader
//   Read-side companion of the psum data storer. Pulls filter and IFMap words
//   from two ready/valid streams into local scratchpads, then replays them as a
//   1-D sliding-window convolution beat stream (v, done, ifmap_out, filt_out)
//   for the multiplier. The storer's stall holds the current beat in place.
//
//   Optional feature: define DATA_LOADER_REUSE_FILTER_EN to let a start with
//   reuse_filt=1 skip the filter load when the same n/filt_len filters are
//   already resident. Without the macro every run loads filters.
// -----------------------------------------------------------------------------
module data_loader #(
   parameter int IFMap_WIDTH       = 8,
   parameter int FILTER_WIDTH      = 8,
   parameter int IFMap_ADDR_WIDTH  = 4,
   parameter int FILTER_ADDR_WIDTH = 4,
   parameter int N_WIDTH           = 4
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          start,
   input  logic                          reuse_filt,
   input  logic [N_WIDTH-1:0]            n,
   input  logic [FILTER_ADDR_WIDTH-1:0]  filt_len,
   input  logic [IFMap_ADDR_WIDTH:0]     ifmap_len,
   input  logic [IFMap_ADDR_WIDTH-1:0]   stride,
   input  logic                          filt_valid,
   input  logic [FILTER_WIDTH-1:0]       filt_din,
   output logic                          filt_ren,
   input  logic                          ifmap_valid,
   input  logic [IFMap_WIDTH-1:0]        ifmap_din,
   output logic                          ifmap_ren,
   input  logic                          stall,
   output logic                          v,
   output logic                          done,
   output logic [IFMap_WIDTH-1:0]        ifmap_out,
   output logic [FILTER_WIDTH-1:0]       filt_out,
   output logic                          busy,
   output logic                          err
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD_F  = 3'd1;
   localparam logic [2:0] ST_LOAD_I  = 3'd2;
   localparam logic [2:0] ST_COMPUTE = 3'd3;
   localparam logic [2:0] ST_DRAIN   = 3'd4;

   localparam int IDEPTH = 2 ** IFMap_ADDR_WIDTH;
   localparam int FDEPTH = 2 ** FILTER_ADDR_WIDTH;
   // Width of n*S before range check.
   localparam int PW     = N_WIDTH + FILTER_ADDR_WIDTH;
   // Window-base arithmetic width: b + stride + S never wraps here.
   localparam int BW     = IFMap_ADDR_WIDTH + 2;

   logic [2:0]                   state;

   // Latched run configuration
   logic [N_WIDTH-1:0]           cfg_n;
   logic [FILTER_ADDR_WIDTH-1:0] cfg_s;
   logic [IFMap_ADDR_WIDTH:0]    cfg_w;
   logic [IFMap_ADDR_WIDTH-1:0]  cfg_stride;
   logic [FILTER_ADDR_WIDTH:0]   cfg_ns;

   // Load counters (also the scratchpad write addresses)
   logic [FILTER_ADDR_WIDTH:0]   f_cnt;
   logic [IFMap_ADDR_WIDTH:0]    i_cnt;

   // Compute counters: window base, filter index, tap; fbase tracks k*S
   logic [IFMap_ADDR_WIDTH:0]    cb;
   logic [N_WIDTH-1:0]           ck;
   logic [FILTER_ADDR_WIDTH-1:0] cs;
   logic [FILTER_ADDR_WIDTH:0]   fbase;

   // Scratchpads
   logic [IFMap_WIDTH-1:0]       imem [IDEPTH];
   logic [FILTER_WIDTH-1:0]      fmem [FDEPTH];

   // Derived control
   logic [PW-1:0]                start_ns;
   logic                         cfg_bad;
   logic                         reuse_hit;
   logic                         f_last;
   logic                         i_last;
   logic [IFMap_ADDR_WIDTH-1:0]  i_addr;
   logic [FILTER_ADDR_WIDTH-1:0] f_addr;
   logic [BW-1:0]                next_b;
   logic                         last_s;
   logic                         last_k;
   logic                         last_b;

   // Stream pops are combinational on valid while the matching load runs.
   assign filt_ren  = (state == ST_LOAD_F) && filt_valid;
   assign ifmap_ren = (state == ST_LOAD_I) && ifmap_valid;
   assign busy      = (state != ST_IDLE);

   // Start legality: all fields non-zero, window fits row, row fits SPAD,
   // all filters fit the filter SPAD.
   assign start_ns = PW'(n) * PW'(filt_len);
   assign cfg_bad  = (n == '0) || (filt_len == '0) || (stride == '0)
                  || (32'(filt_len) > 32'(ifmap_len))
                  || (32'(ifmap_len) > 32'(IDEPTH))
                  || (32'(start_ns) > 32'(FDEPTH));

   assign f_last = filt_ren  && ((f_cnt + 1'b1) == cfg_ns);
   assign i_last = ifmap_ren && ((i_cnt + 1'b1) == cfg_w);

   // Read addresses for the beat about to be issued
   assign i_addr = IFMap_ADDR_WIDTH'(cb + (IFMap_ADDR_WIDTH + 1)'(cs));
   assign f_addr = FILTER_ADDR_WIDTH'(fbase + (FILTER_ADDR_WIDTH + 1)'(cs));

   // Loop-end decode for the tap, filter and window counters
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      last_s = 1'b0;
      last_k = 1'b0;
      last_b = 1'b0;
      next_b = BW'(cb) + BW'(cfg_stride);
      last_s = (cs == cfg_s - 1'b1);
      last_k = (ck == cfg_n - 1'b1);
      last_b = (next_b + BW'(cfg_s)) > BW'(cfg_w);
   end

`ifdef DATA_LOADER_REUSE_FILTER_EN
   logic filt_loaded;
   logic same_shape;

   assign same_shape = (n == cfg_n) && (filt_len == cfg_s);
   assign reuse_hit  = reuse_filt && filt_loaded && same_shape;

   // Track whether the filter SPAD holds a complete set for cfg_n/cfg_s.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         filt_loaded <= 1'b0;
      end else if ((state == ST_IDLE) && start && !cfg_bad && !same_shape) begin
         filt_loaded <= 1'b0;
      end else if (f_last) begin
         filt_loaded <= 1'b1;
      end
   end
`else
   logic unused_reuse;

   assign unused_reuse = reuse_filt;
   assign reuse_hit    = 1'b0;
`endif

   // Scratchpad writes, one word per stream pop in ascending address order.
   always_ff @(posedge clk) begin
      // NOTE: memory arrays are not reset; only valid words are ever read back.
      if (rstn && filt_ren)  fmem[f_cnt[FILTER_ADDR_WIDTH-1:0]] <= filt_din;
      if (rstn && ifmap_ren) imem[i_cnt[IFMap_ADDR_WIDTH-1:0]]  <= ifmap_din;
   end

   // Sequencer: config latch, load counters, compute loop and output register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      if (!rstn) begin
         state      <= ST_IDLE;
         cfg_n      <= '0;
         cfg_s      <= '0;
         cfg_w      <= '0;
         cfg_stride <= '0;
         cfg_ns     <= '0;
         f_cnt      <= '0;
         i_cnt      <= '0;
         cb         <= '0;
         ck         <= '0;
         cs         <= '0;
         fbase      <= '0;
         v          <= 1'b0;
         done       <= 1'b0;
         ifmap_out  <= '0;
         filt_out   <= '0;
         err        <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (cfg_bad) begin
                     err <= 1'b1;
                  end else begin
                     cfg_n      <= n;
                     cfg_s      <= filt_len;
                     cfg_w      <= ifmap_len;
                     cfg_stride <= stride;
                     cfg_ns     <= (FILTER_ADDR_WIDTH + 1)'(start_ns);
                     f_cnt      <= '0;
                     i_cnt      <= '0;
                     state      <= reuse_hit ? ST_LOAD_I : ST_LOAD_F;
                  end
               end
            end

            ST_LOAD_F: begin
               if (f_last) begin
                  f_cnt <= '0;
                  state <= ST_LOAD_I;
               end else if (filt_ren) begin
                  f_cnt <= f_cnt + 1'b1;
               end
            end

            ST_LOAD_I: begin
               if (i_last) begin
                  i_cnt <= '0;
                  cb    <= '0;
                  ck    <= '0;
                  cs    <= '0;
                  fbase <= '0;
                  state <= ST_COMPUTE;
               end else if (ifmap_ren) begin
                  i_cnt <= i_cnt + 1'b1;
               end
            end

            ST_COMPUTE: begin
               // The SPAD read registers double as the beat output register.
               if (!stall) begin
                  v         <= 1'b1;
                  done      <= last_s;
                  ifmap_out <= imem[i_addr];
                  filt_out  <= fmem[f_addr];
                  if (!last_s) begin
                     cs <= cs + 1'b1;
                  end else begin
                     cs <= '0;
                     if (!last_k) begin
                        ck    <= ck + 1'b1;
                        fbase <= fbase + {1'b0, cfg_s};
                     end else begin
                        ck    <= '0;
                        fbase <= '0;
                        if (last_b) begin
                           state <= ST_DRAIN;
                        end else begin
                           cb <= (IFMap_ADDR_WIDTH + 1)'(next_b);
                        end
                     end
                  end
               end
            end

            ST_DRAIN: begin
               // Final beat stays on the outputs until the storer takes it.
               if (!stall) begin
                  v     <= 1'b0;
                  done  <= 1'b0;
                  cb    <= '0;
                  state <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_loader.sv
// -----------------------------------------------------------------------------
// tb_data_loader
//   Directed bench for data_loader. A queue-based model expands each run's
//   configuration into the expected beat list; one compare process checks every
//   valid output cycle against it. Literal sequences pin the model.
// -----------------------------------------------------------------------------
module tb_data_loader;

   logic       clk = 1'b0;
   logic       rstn;
   logic       start;
   logic       reuse_filt;
   logic [3:0] n;
   logic [3:0] filt_len;
   logic [4:0] ifmap_len;
   logic [3:0] stride;
   logic       filt_valid;
   logic [7:0] filt_din;
   logic       filt_ren;
   logic       ifmap_valid;
   logic [7:0] ifmap_din;
   logic       ifmap_ren;
   logic       stall;
   logic       v;
   logic       done;
   logic [7:0] ifmap_out;
   logic [7:0] filt_out;
   logic       busy;
   logic       err;

   data_loader dut (
      .clk         (clk),
      .rstn        (rstn),
      .start       (start),
      .reuse_filt  (reuse_filt),
      .n           (n),
      .filt_len    (filt_len),
      .ifmap_len   (ifmap_len),
      .stride      (stride),
      .filt_valid  (filt_valid),
      .filt_din    (filt_din),
      .filt_ren    (filt_ren),
      .ifmap_valid (ifmap_valid),
      .ifmap_din   (ifmap_din),
      .ifmap_ren   (ifmap_ren),
      .stall       (stall),
      .v           (v),
      .done        (done),
      .ifmap_out   (ifmap_out),
      .filt_out    (filt_out),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int i;
      int f;
      bit d;
   } beat_t;

   int    checks = 0;
   int    errors = 0;
   beat_t exp_q[$];
   int    fdat[$];
   int    idat[$];
   int    cap_i[$];
   int    cap_f[$];
   int    exp_idx = 0;
   int    vcyc = 0;
   int    fren_cnt = 0;
   bit    cmp_en = 1'b0;
   int    stall_at = -1;
   int    stall_left = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: expand the convolution loop nest into the ordered beat list.
   task automatic build_model(input int nn, input int ss, input int ww, input int st);
      beat_t bt;
      exp_q.delete();
      for (int b = 0; b + ss <= ww; b += st)
         for (int k = 0; k < nn; k++)
            for (int s = 0; s < ss; s++) begin
               bt.i = idat[b + s];
               bt.f = fdat[k * ss + s];
               bt.d = (s == ss - 1);
               exp_q.push_back(bt);
            end
   endtask

   // Compare every valid output cycle with the model's current beat.
   always @(negedge clk) begin
      if (filt_ren) fren_cnt++;
      if (cmp_en && v) begin
         vcyc++;
         check("busy_with_v", busy, 1);
         if (exp_idx < exp_q.size()) begin
            check("beat_ifmap", ifmap_out, exp_q[exp_idx].i);
            check("beat_filt", filt_out, exp_q[exp_idx].f);
            check("beat_done", done, exp_q[exp_idx].d);
            if (!stall) begin
               cap_i.push_back(int'(ifmap_out));
               cap_f.push_back(int'(filt_out));
               exp_idx++;
            end
         end else begin
            check("beat_overrun", v, 0);
         end
      end
   end

   // Storer back-pressure: raise stall for stall_left cycles on beat stall_at.
   always @(posedge clk) begin
      #1;
      if (stall_left > 0 && v && exp_idx == stall_at) begin
         stall = 1'b1;
         stall_left--;
      end else begin
         stall = 1'b0;
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_v"}, v, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_ifmap_out"}, ifmap_out, 0);
      check({tag, "_filt_out"}, filt_out, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_filt_ren"}, filt_ren, 0);
      check({tag, "_ifmap_ren"}, ifmap_ren, 0);
   endtask

   task automatic issue_start(input int nn, input int ss, input int ww, input int st, input bit ru);
      n = 4'(nn); filt_len = 4'(ss); ifmap_len = 5'(ww); stride = 4'(st); reuse_filt = ru;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_case(input int nn, input int ss, input int ww, input int st,
                           input bit ru, input bit fload, input int s_at, input int s_n,
                           input bit gap, input int abort_at);
      int t;
      build_model(nn, ss, ww, st);
      exp_idx = 0; vcyc = 0; fren_cnt = 0;
      cap_i.delete(); cap_f.delete();
      stall_at = s_at; stall_left = s_n;
      cmp_en = 1'b1;
      issue_start(nn, ss, ww, st, ru);
      check("busy_after_start", busy, 1);
      if (fload) begin
         for (int i = 0; i < nn * ss; i++) begin
            filt_din = 8'(fdat[i]);
            filt_valid = 1'b1;
            if (gap && i == 1) begin
               filt_valid = 1'b0;
               @(posedge clk); #1;
               check("paused_filt_ren", filt_ren, 0);
               filt_valid = 1'b1;
            end
            t = 0;
            do begin @(negedge clk); t++; end while (!filt_ren && t < 50);
            if (!filt_ren) check("filt_pop_timeout", filt_ren, 1);
            @(posedge clk); #1;
         end
         filt_valid = 1'b0;
      end else begin
         ifmap_valid = 1'b1;
         ifmap_din = 8'(idat[0]);
         #1 check("reuse_ifmap_ren", ifmap_ren, 1);
      end
      for (int i = 0; i < ww; i++) begin
         ifmap_din = 8'(idat[i]);
         ifmap_valid = 1'b1;
         t = 0;
         do begin @(negedge clk); t++; end while (!ifmap_ren && t < 50);
         if (!ifmap_ren) check("ifmap_pop_timeout", ifmap_ren, 1);
         @(posedge clk); #1;
      end
      ifmap_valid = 1'b0;
      if (abort_at >= 0) begin
         t = 0;
         do begin @(posedge clk); #1; t++; end while (!(v && exp_idx == abort_at) && t < 200);
         check("abort_point_v", v, 1);
         rstn = 1'b0;
         @(posedge clk); #1;
         cmp_en = 1'b0;
         check_idle_outputs("mid_reset");
         rstn = 1'b1;
         @(posedge clk); #1;
         return;
      end
      t = 0;
      while (busy && t < 400) begin @(negedge clk); t++; end
      check("run_end_busy", busy, 0);
      @(posedge clk); #1;
      cmp_en = 1'b0;
      check("beat_count", exp_idx, exp_q.size());
      check("v_cycles", vcyc, exp_q.size() + s_n);
      check("filt_pops", fren_cnt, fload ? nn * ss : 0);
      check("v_after_run", v, 0);
   endtask

   task automatic bad_start(input int nn, input int ss, input int ww, input int st);
      filt_valid = 1'b1;
      issue_start(nn, ss, ww, st, 1'b0);
      check("bad_err_pulse", err, 1);
      check("bad_busy", busy, 0);
      check("bad_filt_ren", filt_ren, 0);
      @(posedge clk); #1;
      check("bad_err_clear", err, 0);
      check("bad_busy_later", busy, 0);
      filt_valid = 1'b0;
   endtask

   task automatic check_lit_case1(input string tag);
      int lit_i[9];
      int lit_d[9];
      lit_i = '{1, 2, 3, 2, 3, 4, 3, 4, 5};
      lit_d = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
      check({tag, "_count"}, cap_i.size(), 9);
      for (int i = 0; i < 9; i++) begin
         check({tag, "_ifmap"}, cap_i[i], lit_i[i]);
         check({tag, "_done_model"}, exp_q[i].d, lit_d[i]);
      end
   endtask

   initial begin
      int lit_f[8];
      int lit_i[8];
      rstn = 1'b0; start = 1'b0; reuse_filt = 1'b0;
      n = '0; filt_len = '0; ifmap_len = '0; stride = '0;
      filt_valid = 1'b0; filt_din = '0; ifmap_valid = 1'b0; ifmap_din = '0;
      stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rstn = 1'b1;
      @(posedge clk); #1;

      // Case 1: n=1, S=3, W=5, stride=1
      fdat = '{1, 1, 1};
      idat = '{1, 2, 3, 4, 5};
      run_case(1, 3, 5, 1, 1'b0, 1'b1, -1, 0, 1'b0, -1);
      check_lit_case1("case1");

      // Case 2: two filters
      fdat = '{1, 2, 3, 4};
      idat = '{5, 6, 7};
      run_case(2, 2, 3, 1, 1'b0, 1'b1, -1, 0, 1'b0, -1);
      lit_f = '{1, 2, 3, 4, 1, 2, 3, 4};
      lit_i = '{5, 6, 5, 6, 6, 7, 6, 7};
      check("case2_count", cap_f.size(), 8);
      for (int i = 0; i < 8; i++) begin
         check("case2_filt", cap_f[i], lit_f[i]);
         check("case2_ifmap", cap_i[i], lit_i[i]);
      end

      // Case 1 with a 3-cycle stall on beat 4
      fdat = '{1, 1, 1};
      idat = '{1, 2, 3, 4, 5};
      run_case(1, 3, 5, 1, 1'b0, 1'b1, 3, 3, 1'b0, -1);
      check_lit_case1("stall");

      // Illegal starts
      bad_start(1, 6, 5, 1);
      bad_start(4, 5, 5, 1);
      bad_start(0, 2, 5, 1);
      bad_start(1, 2, 17, 1);

      // Full-depth row, stride equal to S
      fdat = '{2, 3, 5, 7};
      idat.delete();
      for (int i = 0; i < 16; i++) idat.push_back(16 + i);
      run_case(1, 4, 16, 4, 1'b0, 1'b1, -1, 0, 1'b0, -1);
      check("w16_last_ifmap", cap_i[15], 31);

      // Stride 2 leaving a tail, with a paused filter stream
      fdat = '{9, 8, 7, 6, 5, 4};
      idat = '{10, 11, 12, 13, 14, 15, 16};
      run_case(2, 3, 7, 2, 1'b0, 1'b1, -1, 0, 1'b1, -1);
      check("s2_count", cap_i.size(), 18);

      // Reset during beat 5, then a fresh case-1 run
      fdat = '{1, 1, 1};
      idat = '{1, 2, 3, 4, 5};
      run_case(1, 3, 5, 1, 1'b0, 1'b1, -1, 0, 1'b0, 4);
      run_case(1, 3, 5, 1, 1'b0, 1'b1, -1, 0, 1'b0, -1);
      check_lit_case1("after_reset");

      // Second start with reuse_filt and the same n/S
`ifdef DATA_LOADER_REUSE_FILTER_EN
      run_case(1, 3, 5, 1, 1'b1, 1'b0, -1, 0, 1'b0, -1);
`else
      run_case(1, 3, 5, 1, 1'b1, 1'b1, -1, 0, 1'b0, -1);
`endif
      check_lit_case1("reuse");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
